instr_fetch: RTL and testbench

Instruction-fetch stage directly downstream of the program counter. It owns the instruction memory, consumes prog_ctr each cycle, and registers the addressed instruction with its PC for decode. A small run-control FSM sequences IDLE/RUN/HALT, detects the halt opcode and raises done. A write port loads programs while idle.

---
 rtl/instr_fetch_if.sv | 31 +++
 rtl/instr_fetch.sv | 144 ++++++++++++++
 tb/tb_instr_fetch.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: run control, PC in, program-load port, fetched instruction and status out.
// slave is the fetch stage's view; master is the driver (PC unit / loader / bench).
interface instr_fetch_if #(
  parameter int D  = 12,
  parameter int W  = 9,
  parameter int CW = 16
);
  logic          start;
  logic [D-1:0]  prog_ctr;
  logic          stall;
  logic          flush;
  logic          load_en;
  logic [D-1:0]  load_addr;
  logic [W-1:0]  load_data;
  logic [W-1:0]  instr;
  logic [D-1:0]  instr_pc;
  logic          instr_valid;
  logic          done;
  logic          addr_err;
  logic [CW-1:0] fetch_count;

  modport slave (
    input  start, prog_ctr, stall, flush, load_en, load_addr, load_data,
    output instr, instr_pc, instr_valid, done, addr_err, fetch_count
  );

  modport master (
    output start, prog_ctr, stall, flush, load_en, load_addr, load_data,
    input  instr, instr_pc, instr_valid, done, addr_err, fetch_count
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the instruction memory, registers mem[prog_ctr] with its PC,
// and sequences IDLE/RUN/HALT with halt-opcode detection and a program-load port usable in IDLE.
module instr_fetch #(
  parameter int             D       = 12,
  parameter int             W       = 9,
  parameter int             DEPTH   = 1024,
  parameter logic [W-1:0]   HALT_OP = 9'h1FF,
  parameter int             CW      = 16
) (
  input  logic         clk,
  input  logic         reset,
  instr_fetch_if.slave bus
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [D:0]  DEPTH_X = (D+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_e;

  state_e        state_q, state_d;
  logic          start_q;
  logic          valid_q, valid_d;
  logic          clr_q, clr_d;
  logic [D-1:0]  pc_q, pc_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [W-1:0]  mem [DEPTH];
  logic [W-1:0]  rd_data_q;
  logic          rd_en, wr_en;
  logic          launch, pc_in_range, ld_in_range, halt_hit;
  logic [W-1:0]  instr_out;

  assign launch      = start_q & ~bus.start;
  assign pc_in_range = ({1'b0, bus.prog_ctr}  < DEPTH_X);
  assign ld_in_range = ({1'b0, bus.load_addr} < DEPTH_X);

  // rd_data_q is the RAM output register; clr_q masks it so flush/reset can zero instr
  // without needing a reset on the memory read path.
  assign instr_out = clr_q ? '0 : rd_data_q;
  assign halt_hit  = valid_q && (instr_out == HALT_OP);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[bus.load_addr[AW-1:0]] <= bus.load_data;
    end
    if (rd_en) begin
      rd_data_q <= mem[bus.prog_ctr[AW-1:0]];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      clr_q   <= 1'b1;
      pc_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      start_q <= bus.start;
      valid_q <= valid_d;
      clr_q   <= clr_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    clr_d   = clr_q;
    pc_d    = pc_q;
    done_d  = done_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    rd_en   = 1'b0;
    wr_en   = (state_q == S_IDLE) && bus.load_en && ld_in_range;

    if (bus.start) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          valid_d = 1'b0;
          if (launch) begin
            state_d = S_RUN;
            done_d  = 1'b0;
            err_d   = 1'b0;
            cnt_d   = '0;
          end
        end
        S_RUN: begin
          // The halt word has been presented for its one cycle; retire it before any other action.
          if (halt_hit) begin
            state_d = S_HALT;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else if (bus.flush) begin
            valid_d = 1'b0;
            clr_d   = 1'b1;
            pc_d    = '0;
          end else if (bus.stall) begin
            valid_d = valid_q;
          end else if (!pc_in_range) begin
            valid_d = 1'b0;
            clr_d   = 1'b1;
            pc_d    = '0;
            err_d   = 1'b1;
          end else begin
            rd_en   = 1'b1;
            clr_d   = 1'b0;
            valid_d = 1'b1;
            pc_d    = bus.prog_ctr;
            cnt_d   = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);
          end
        end
        S_HALT: begin
          valid_d = 1'b0;
          done_d  = 1'b1;
        end
        default: begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  assign bus.instr       = instr_out;
  assign bus.instr_pc    = pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.done        = done_q;
  assign bus.addr_err    = err_q;
  assign bus.fetch_count = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a behavioural model predicts each delivered instruction and
// the status outputs; a negedge monitor pops and compares independently of the stimulus.
module tb_instr_fetch;
  localparam int         D       = 12;
  localparam int         W       = 9;
  localparam int         DEPTH   = 1024;
  localparam int         CW      = 16;
  localparam logic [8:0] HALT_OP = 9'h1FF;
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_fetch_if #(.D(D), .W(W), .CW(CW)) bus ();

  instr_fetch #(.D(D), .W(W), .DEPTH(DEPTH), .HALT_OP(HALT_OP), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  typedef struct { logic [8:0] instr; logic [11:0] pc; } exp_t;
  exp_t sbq[$];

  logic [8:0]  m_mem [DEPTH];
  int          m_mode;
  bit          m_start_prev;
  logic [8:0]  m_instr;
  logic [11:0] m_pc;
  bit          m_valid, m_done, m_err;
  int          m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_start_prev = 0;
    m_instr = '0; m_pc = '0; m_valid = 0; m_done = 0; m_err = 0; m_cnt = 0;
    sbq.delete();
  endtask

  // Behavioural rules evaluated once per rising edge from the inputs the DUT samples there.
  task automatic model_step();
    bit s, launch;
    int old_mode, pc;
    s = bus.start;
    launch = m_start_prev && !s;
    m_start_prev = s;
    old_mode = m_mode;
    pc = int'(bus.prog_ctr);
    if (old_mode == M_IDLE && bus.load_en && int'(bus.load_addr) < DEPTH)
      m_mem[int'(bus.load_addr)] = bus.load_data;
    if (s) begin
      m_mode = M_IDLE; m_valid = 0;
    end else if (old_mode == M_IDLE) begin
      m_valid = 0;
      if (launch) begin m_mode = M_RUN; m_done = 0; m_err = 0; m_cnt = 0; end
    end else if (old_mode == M_RUN) begin
      if (m_valid && m_instr == HALT_OP) begin
        m_mode = M_HALT; m_valid = 0; m_done = 1;
      end else if (bus.flush) begin
        m_valid = 0; m_instr = '0; m_pc = '0;
      end else if (bus.stall) begin
        // everything holds
      end else if (pc >= DEPTH) begin
        m_valid = 0; m_instr = '0; m_pc = '0; m_err = 1;
      end else begin
        m_instr = m_mem[pc]; m_pc = 12'(pc); m_valid = 1;
        if (m_cnt < 65535) m_cnt++;
      end
    end else begin
      m_valid = 0;
    end
    if (m_valid) sbq.push_back('{m_instr, m_pc});
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.instr_valid) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_valid: got instr %0h pc %0h expected no valid", bus.instr, bus.instr_pc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("sb_instr", 32'(bus.instr), 32'(e.instr));
          check("sb_pc", 32'(bus.instr_pc), 32'(e.pc));
        end
      end else if (sbq.size() != 0) begin
        checks++; errors++;
        $display("FAIL missing_valid: got valid 0 expected instr %0h", sbq[0].instr);
        sbq.delete();
      end
      check("done", 32'(bus.done), 32'(m_done));
      check("addr_err", 32'(bus.addr_err), 32'(m_err));
      check("fetch_count", 32'(bus.fetch_count), 32'(m_cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [8:0] v);
    bus.load_en = 1; bus.load_addr = 12'(a); bus.load_data = v;
    tick();
    bus.load_en = 0;
  endtask

  task automatic launch_run();
    bus.start = 1; tick();
    bus.start = 0; tick();
  endtask

  task automatic fetch(input int pc, input bit st, input bit fl);
    bus.prog_ctr = 12'(pc); bus.stall = st; bus.flush = fl;
    tick();
    bus.stall = 0; bus.flush = 0;
  endtask

  initial begin
    int pc_r, r, p;
    logic [8:0] v;
    bus.start = 1; bus.prog_ctr = '0; bus.stall = 0; bus.flush = 0;
    bus.load_en = 0; bus.load_addr = '0; bus.load_data = '0;
    reset = 1;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 0;
    #1;
    check("rst_instr", 32'(bus.instr), 0);
    check("rst_valid", 32'(bus.instr_valid), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_err", 32'(bus.addr_err), 0);
    check("rst_count", 32'(bus.fetch_count), 0);
    mon_en = 1;

    for (int a = 0; a < DEPTH; a++) begin
      v = ($urandom_range(0, 99) < 2) ? HALT_OP : 9'($urandom_range(0, 510));
      load(a, v);
    end
    load(0, 9'h011); load(1, 9'h022); load(2, 9'h033); load(3, 9'h1FF);
    load(1500, 9'h155);

    // Basic program to halt
    launch_run();
    fetch(0, 0, 0); check("p_instr0", 32'(bus.instr), 32'h011);
    fetch(1, 0, 0); check("p_instr1", 32'(bus.instr), 32'h022);
    fetch(2, 0, 0); check("p_instr2", 32'(bus.instr), 32'h033);
    fetch(3, 0, 0); check("p_instr3", 32'(bus.instr), 32'h1FF);
    check("p_valid3", 32'(bus.instr_valid), 1);
    fetch(4, 0, 0);
    check("halt_done", 32'(bus.done), 1);
    check("halt_valid", 32'(bus.instr_valid), 0);
    check("halt_count", 32'(bus.fetch_count), 4);
    fetch(0, 0, 0); check("halt_hold_valid", 32'(bus.instr_valid), 0);

    // Stall hold, then stall+flush
    launch_run();
    check("relaunch_done", 32'(bus.done), 0);
    fetch(0, 0, 0); fetch(1, 0, 0); fetch(2, 0, 0);
    for (int k = 0; k < 3; k++) begin
      fetch(3, 1, 0);
      check("stall_instr", 32'(bus.instr), 32'h033);
      check("stall_pc", 32'(bus.instr_pc), 2);
      check("stall_count", 32'(bus.fetch_count), 3);
    end
    fetch(3, 1, 1); check("stallflush_valid", 32'(bus.instr_valid), 0);

    // Flush suppresses halt fetch
    fetch(3, 0, 1);
    check("flushhalt_valid", 32'(bus.instr_valid), 0);
    check("flushhalt_done", 32'(bus.done), 0);
    fetch(0, 0, 0);
    check("after_flush_instr", 32'(bus.instr), 32'h011);
    check("after_flush_valid", 32'(bus.instr_valid), 1);

    // Out-of-range PC
    fetch(1024, 0, 0);
    check("oor_valid", 32'(bus.instr_valid), 0);
    check("oor_err", 32'(bus.addr_err), 1);
    fetch(0, 0, 0); check("oor_sticky", 32'(bus.addr_err), 1);
    launch_run(); check("oor_cleared", 32'(bus.addr_err), 0);

    // Writes outside IDLE are ignored; out-of-range write must not alias
    bus.load_en = 1; bus.load_addr = 12'd1; bus.load_data = 9'h0AA;
    fetch(0, 0, 0);
    bus.load_en = 0;
    launch_run();
    fetch(1, 0, 0); check("run_write_ignored", 32'(bus.instr), 32'h022);
    fetch(476, 0, 0); check("oor_write_alias", 32'(bus.instr), 32'(m_mem[476]));

    // Asynchronous reset between edges
    fetch(2, 0, 0);
    #1 reset = 1;
    #1;
    check("arst_instr", 32'(bus.instr), 0);
    check("arst_valid", 32'(bus.instr_valid), 0);
    check("arst_count", 32'(bus.fetch_count), 0);
    model_reset();
    #1 reset = 0;
    launch_run();
    fetch(0, 0, 0); check("arst_relaunch", 32'(bus.instr), 32'h011);

    // Randomized traffic
    pc_r = 0;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      bus.start = (m_mode == M_HALT) || (r < 2);
      bus.stall = ($urandom_range(0, 99) < 20);
      bus.flush = ($urandom_range(0, 99) < 10);
      p = $urandom_range(0, 99);
      if (p < 5)       pc_r = $urandom_range(1024, 4095);
      else if (p < 15) pc_r = $urandom_range(0, 1023);
      else             pc_r = (pc_r + 1) % 1024;
      bus.prog_ctr  = 12'(pc_r);
      bus.load_en   = ($urandom_range(0, 99) < 15);
      bus.load_addr = 12'($urandom_range(0, 1100));
      bus.load_data = 9'($urandom_range(0, 510));
      tick();
    end
    bus.stall = 0; bus.flush = 0; bus.load_en = 0;
    bus.start = 1; tick(); tick();
    mon_en = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
